fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the pipelined MIPS core. Sits directly upstream of the IF/ID latch (latch1).
- Owns the PC register, next-PC selection and the request/response handshake to instruction memory.
- Delivers instrF and pcplus4F to latch1.
- Takes stall from the hazard unit and branch/jump redirects from the decode stage.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/pc_next_sel.sv | 34 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Imported by fetch_stage and pc_next_sel.
package fetch_pkg;

    // Default datapath width and reset vector of the fetch stage.
    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam int          PC_INC           = 4;

    // Fetch FSM encoding, kept as plain 2-bit constants so older code that
    // compares raw state bits keeps working.
    localparam logic [1:0] ST_FETCH   = 2'd0;  // issue request for pc_q
    localparam logic [1:0] ST_WAIT    = 2'd1;  // one request outstanding
    localparam logic [1:0] ST_HOLD    = 2'd2;  // output held by stallF
    localparam logic [1:0] ST_DISCARD = 2'd3;  // drain a redirected request

    typedef enum logic [1:0] {
        FETCH   = ST_FETCH,
        WAIT    = ST_WAIT,
        HOLD    = ST_HOLD,
        DISCARD = ST_DISCARD
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc_q          current fetch PC
//   branch_taken  decode asks for a branch redirect (highest priority)
//   branch_target branch destination (bits [1:0] ignored)
//   jump          decode asks for a jump redirect
//   jump_target   jump destination (bits [1:0] ignored)
//   redirect      either redirect is requested this cycle
//   pc_plus4      sequential successor of pc_q, wrapping modulo 2^W
//   target        word-aligned redirect destination, branch over jump
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int W = XLEN_DEFAULT
) (
    input  logic [W-1:0] pc_q,
    input  logic         branch_taken,
    input  logic [W-1:0] branch_target,
    input  logic         jump,
    input  logic [W-1:0] jump_target,
    output logic         redirect,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] target
);

    logic [W-1:0] raw_target;

    assign redirect   = branch_taken | jump;
    assign pc_plus4   = pc_q + W'(PC_INC);
    assign raw_target = branch_taken ? branch_target : jump_target;
    // Instructions are word aligned; the low two bits are forced to zero.
    assign target     = raw_target & ~W'(3);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and presents the fetched word to the IF/ID latch.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   stallF                    hazard unit holds the delivered instruction
//   branch_taken/branch_target  branch redirect from decode
//   jump/jump_target          jump redirect from decode
//   imem_req/imem_addr        request pulse and address to instruction memory
//   imem_rvalid/imem_rdata    response strobe and instruction word
//   instrF/pcplus4F/validF    delivered instruction, its PC+4, and valid flag
//   dbg_state                 current FSM state (fetch_pkg ST_* encoding)
//
// Memory handshake: imem_req is a single-cycle pulse in FETCH carrying
// imem_addr. Exactly one imem_rvalid strobe answers each request, one or more
// cycles later, and no new request is issued until it has arrived. Delivery
// handshake: validF=1 offers instrF/pcplus4F; it is taken on any cycle with
// stallF=0, and validF drops at the next edge unless a new word is captured
// on that same edge.
module fetch_stage #(
    parameter int               XLEN     = fetch_pkg::XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(fetch_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instrF,
    output logic [XLEN-1:0] pcplus4F,
    output logic            validF,
    output logic [1:0]      dbg_state
);
    import fetch_pkg::*;

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ~XLEN'(3);

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] instr_nxt, pc4_nxt;
    logic            valid_nxt;
    logic            capture;

    logic            redirect;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;

    pc_next_sel #(.W(XLEN)) u_pc_next_sel (
        .pc_q          (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .pc_plus4      (pc_plus4),
        .target        (target)
    );

    assign imem_req  = (state == ST_FETCH) && !rst;
    assign imem_addr = pc_q;
    assign dbg_state = state;

    // A response is only kept when it answers a live request and no redirect
    // arrives on the same cycle; a redirect makes that word stale.
    assign capture = (state == ST_WAIT) && imem_rvalid && !redirect;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instrF;
        pc4_nxt   = pcplus4F;
        valid_nxt = validF;

        if (validF && !stallF) begin
            valid_nxt = 1'b0;
        end

        case (state)
            ST_FETCH:   state_nxt = ST_WAIT;
            ST_WAIT:    if (imem_rvalid) state_nxt = stallF ? ST_HOLD : ST_FETCH;
            ST_HOLD:    if (!stallF) state_nxt = ST_FETCH;
            ST_DISCARD: if (imem_rvalid) state_nxt = ST_FETCH;
            default:    state_nxt = ST_FETCH;
        endcase

        // Capture takes precedence over consumption on the same edge.
        if (capture) begin
            instr_nxt = imem_rdata;
            pc4_nxt   = pc_plus4;
            pc_nxt    = pc_plus4;
            valid_nxt = 1'b1;
        end

        // Redirect overrides stall and any capture. While a request is still
        // in flight the stage must drain it in DISCARD before issuing again;
        // if the response lands this very cycle there is nothing left to drain.
        if (redirect) begin
            pc_nxt    = target;
            valid_nxt = 1'b0;
            instr_nxt = '0;
            case (state)
                ST_FETCH:   state_nxt = ST_DISCARD;
                ST_WAIT:    state_nxt = imem_rvalid ? ST_FETCH : ST_DISCARD;
                ST_DISCARD: state_nxt = imem_rvalid ? ST_FETCH : ST_DISCARD;
                default:    state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc_q     <= RESET_PC_ALIGNED;
            instrF   <= '0;
            pcplus4F <= '0;
            validF   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instrF   <= instr_nxt;
            pcplus4F <= pc4_nxt;
            validF   <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural instruction memory with
// programmable latency, a per-cycle vector table for free-run and stall, and
// hand-written sequences for redirects, reset during a fetch and PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stallF, branch_taken, jump, imem_rvalid;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, validF;
  logic [31:0] imem_addr, instrF, pcplus4F;
  logic [1:0]  dbg_state;

  // second instance, reset vector at the top of the address space
  logic        rst_w, w_rvalid, w_req, w_valid;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc4;
  logic        w_stall, w_branch, w_jump;
  logic [31:0] w_btgt, w_jtgt;
  logic [1:0]  w_dbg_state;

  fetch_stage u_dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instrF        (instrF),
    .pcplus4F      (pcplus4F),
    .validF        (validF),
    .dbg_state     (dbg_state)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .rst           (rst_w),
    .stallF        (w_stall),
    .branch_taken  (w_branch),
    .branch_target (w_btgt),
    .jump          (w_jump),
    .jump_target   (w_jtgt),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_rvalid   (w_rvalid),
    .imem_rdata    (w_rdata),
    .instrF        (w_instr),
    .pcplus4F      (w_pc4),
    .validF        (w_valid),
    .dbg_state     (w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {instr, pcplus4} in delivery order
  int vectors = 0;
  int fails   = 0;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory models ----------------
  int          m_lat  = 1;
  int          m_cnt  = 0;
  logic        m_pend = 1'b0;
  logic        m_drop = 1'b0;   // next response is expected to be thrown away
  logic [31:0] m_addr = '0;
  logic        w_pend = 1'b0;
  logic [31:0] w_addr_s = '0;

  // Runs on the falling edge: checks new deliveries, captures requests.
  task automatic monitor();
    logic [63:0] e;
    if (validF && (!prev_valid || !prev_stall)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL deliver: got instr %h pc4 %h, expected no delivery", instrF, pcplus4F);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_instr", instrF, e[63:32]);
        chk("deliver_pc4", pcplus4F, e[31:0]);
      end
    end
    prev_valid = validF;
    prev_stall = stallF;
    if (rst) m_pend = 1'b0;
    else if (imem_req) begin
      m_pend = 1'b1;
      m_cnt  = m_lat;
      m_addr = imem_addr;
    end
    if (rst_w) w_pend = 1'b0;
    else if (w_req) begin
      w_pend   = 1'b1;
      w_addr_s = w_addr;
    end
  endtask

  // Runs just after the rising edge: drives the response for the new cycle.
  task automatic mem_drive();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_addr ^ MAGIC;
        m_pend      = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else exp_q.push_back({m_addr ^ MAGIC, m_addr + 32'd4});
      end
    end
    w_rvalid = w_pend;
    w_rdata  = w_addr_s ^ MAGIC;
    w_pend   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic step_chk(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] epc4);
    sample();
    chk({tag, "_req"}, 32'(imem_req), 32'(er));
    if (er) chk({tag, "_addr"}, imem_addr, ea);
    chk({tag, "_valid"}, 32'(validF), 32'(ev));
    if (ev) chk({tag, "_pc4"}, pcplus4F, epc4);
    advance();
  endtask

  typedef struct packed {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
    $fatal(1);
  end

  initial begin
    // free run with 1-cycle memory, then a 3-cycle stall over the 0x8 response
    tbl[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h4};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hC};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hC};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC};
    tbl[9]  = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

    rst = 1'b1; rst_w = 1'b1;
    stallF = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    w_stall = 1'b0; w_branch = 1'b0; w_jump = 1'b0; w_btgt = '0; w_jtgt = '0;
    w_rvalid = 1'b0; w_rdata = '0;

    // reset state
    sample();
    advance();
    sample();
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(validF), 32'd0);
    chk("reset_instr", instrF, 32'h0);
    chk("reset_pc4", pcplus4F, 32'h0);
    advance();
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      stallF = tbl[k].stall;
      step_chk($sformatf("tbl%0d", k), tbl[k].req, tbl[k].addr, tbl[k].valid, tbl[k].pc4);
    end
    stallF = 1'b0;

    // redirect while a 3-cycle request to 0x10 is outstanding
    m_lat = 3;
    step_chk("redir_issue", 1'b1, 32'h10, 1'b1, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h100; m_drop = 1'b1;
    step_chk("redir_wait", 1'b0, 32'h0, 1'b0, 32'h0);
    branch_taken = 1'b0;
    step_chk("discard1", 1'b0, 32'h0, 1'b0, 32'h0);
    step_chk("discard2", 1'b0, 32'h0, 1'b0, 32'h0);
    m_lat = 1;
    step_chk("redir_target", 1'b1, 32'h100, 1'b0, 32'h0);
    step_chk("redir_wait2", 1'b0, 32'h0, 1'b0, 32'h0);

    // branch and jump together: branch wins
    branch_taken = 1'b1; branch_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300; m_drop = 1'b1;
    step_chk("both_fetch", 1'b1, 32'h104, 1'b1, 32'h104);
    branch_taken = 1'b0; jump = 1'b0;
    step_chk("both_discard", 1'b0, 32'h0, 1'b0, 32'h0);

    // misaligned jump target is issued word aligned
    jump = 1'b1; jump_target = 32'h303; m_drop = 1'b1;
    step_chk("branch_wins", 1'b1, 32'h200, 1'b0, 32'h0);
    jump = 1'b0;
    step_chk("jump_discard", 1'b0, 32'h0, 1'b0, 32'h0);

    // reset in WAIT on the same cycle as the response
    m_drop = 1'b1;
    step_chk("jump_aligned", 1'b1, 32'h300, 1'b0, 32'h0);
    rst = 1'b1;
    step_chk("rst_in_wait", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    step_chk("rst_restart", 1'b1, 32'h0, 1'b0, 32'h0);
    chk("rst_instr_clear", instrF, 32'h0);
    chk("rst_pc4_clear", pcplus4F, 32'h0);
    step_chk("rst_wait2", 1'b0, 32'h0, 1'b0, 32'h0);
    m_drop = 1'b1;
    step_chk("rst_deliver", 1'b1, 32'h4, 1'b1, 32'h4);

    // PC wrap on the second instance; main core parked in reset
    rst = 1'b1;
    rst_w = 1'b0;
    sample();
    chk("wrap_req0", 32'(w_req), 32'd1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    advance();
    sample();
    chk("wrap_valid1", 32'(w_valid), 32'd0);
    advance();
    sample();
    chk("wrap_valid2", 32'(w_valid), 32'd1);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, 32'h5A5A_FFFC);
    chk("wrap_req2", 32'(w_req), 32'd1);
    chk("wrap_addr2", w_addr, 32'h0);
    advance();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
